// File: rtl/ex_stage.sv
`default_nettype none
//==============================================================================
// Module   : ex_stage
// Brief    : RV32 execute stage with a single-cycle ALU and an optional
//            iterative RV32M multiply/divide unit (macro EX_MULDIV_EN).
// Revision : 1.0
//==============================================================================
module ex_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] src1,
   input  logic [XLEN-1:0] src2,
   input  logic [XLEN-1:0] csrs,
   input  logic [XLEN-1:0] rs2_value,
   input  logic [XLEN-1:0] inst,
   input  logic [3:0]      alu_op,
   input  logic [2:0]      funct3,
   input  logic            muldiv,
   input  logic            mem_ren,
   input  logic            mem_wen,
   input  logic            R_wen,
   input  logic            jump_flag,
   input  logic [3:0]      csr_wen,
   input  logic [4:0]      rd,
   input  logic            valid_last,
   output logic            ready_last,
   output logic            valid_next,
   input  logic            ready_next,
   input  logic            flush,
   output logic [XLEN-1:0] Ex_result_next,
   output logic [XLEN-1:0] pc_next,
   output logic [XLEN-1:0] csrs_next,
   output logic [XLEN-1:0] rs2_value_next,
   output logic [XLEN-1:0] inst_next,
   output logic [4:0]      rd_next,
   output logic [2:0]      funct3_next,
   output logic [3:0]      csr_wen_next,
   output logic            mem_ren_next,
   output logic            mem_wen_next,
   output logic            R_wen_next,
   output logic            jump_flag_next
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t          r_state, w_state_nxt;
   logic            w_busy, w_valid, w_capture;
   logic [XLEN-1:0] w_alu;
   logic [4:0]      w_shamt;

   logic [XLEN-1:0] r_result, r_pc, r_csrs, r_rs2_value, r_inst;
   logic [4:0]      r_rd;
   logic [2:0]      r_funct3;
   logic [3:0]      r_csr_wen;
   logic            r_mem_ren, r_mem_wen, r_R_wen, r_jump_flag;

   assign w_valid    = (r_state == S_DONE);
   assign w_busy     = (r_state == S_MUL) || (r_state == S_DIV);
   assign ready_last = !w_busy && (!w_valid || ready_next);
   assign w_capture  = valid_last && ready_last && !flush;

   assign valid_next     = w_valid;
   assign Ex_result_next = r_result;
   assign pc_next        = r_pc;
   assign csrs_next      = r_csrs;
   assign rs2_value_next = r_rs2_value;
   assign inst_next      = r_inst;
   assign rd_next        = r_rd;
   assign funct3_next    = r_funct3;
   assign csr_wen_next   = r_csr_wen;
   assign mem_ren_next   = r_mem_ren;
   assign mem_wen_next   = r_mem_wen;
   assign R_wen_next     = r_R_wen;
   assign jump_flag_next = r_jump_flag;

   assign w_shamt = src2[4:0];

   always_comb begin
      w_alu = '0;
      case (alu_op)
         4'd0:    w_alu = src1 + src2;
         4'd1:    w_alu = src1 - src2;
         4'd2:    w_alu = src1 << w_shamt;
         4'd3:    w_alu = {{(XLEN-1){1'b0}}, ($signed(src1) < $signed(src2))};
         4'd4:    w_alu = {{(XLEN-1){1'b0}}, (src1 < src2)};
         4'd5:    w_alu = src1 ^ src2;
         4'd6:    w_alu = src1 >> w_shamt;
         4'd7:    w_alu = $signed(src1) >>> w_shamt;
         4'd8:    w_alu = src1 | src2;
         4'd9:    w_alu = src1 & src2;
         4'd10:   w_alu = src2;
         default: w_alu = '0;
      endcase
   end

`ifdef EX_MULDIV_EN
   localparam logic [XLEN-1:0] c_int_min = {1'b1, {(XLEN-1){1'b0}}};

   logic              w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
   logic [XLEN-1:0]   w_a_mag, w_b_mag, w_fast_res;
   logic              w_div_zero, w_div_ovf, w_div_fast, w_last;
   logic [2*XLEN-1:0] r_acc, r_op_a, w_acc_step, w_prod;
   logic [XLEN-1:0]   r_op_b, w_rem_diff, w_quo, w_rem, w_step_res;
   logic [XLEN:0]     w_rem_sh;
   logic              w_rem_ge, r_neg_q, r_neg_r;
   logic [4:0]        r_cnt;

   // Operands are reduced to magnitudes up front; signs are reapplied on the last step.
   always_comb begin
      if (funct3[2]) begin
         w_a_sgn = !funct3[0];
         w_b_sgn = !funct3[0];
      end else begin
         w_a_sgn = (funct3[1:0] == 2'b01) || (funct3[1:0] == 2'b10);
         w_b_sgn = (funct3[1:0] == 2'b01);
      end
      w_a_neg    = w_a_sgn && src1[XLEN-1];
      w_b_neg    = w_b_sgn && src2[XLEN-1];
      w_a_mag    = w_a_neg ? -src1 : src1;
      w_b_mag    = w_b_neg ? -src2 : src2;
      w_div_zero = (src2 == '0);
      w_div_ovf  = !funct3[0] && (src1 == c_int_min) && (src2 == '1);
      w_div_fast = funct3[2] && (w_div_zero || w_div_ovf);
      if (w_div_zero)
         w_fast_res = funct3[1] ? src1 : '1;
      else
         w_fast_res = funct3[1] ? '0 : c_int_min;
   end

   // r_acc holds the product accumulator for MUL, or {remainder, quotient} for DIV.
   always_comb begin
      w_last     = (r_cnt == 5'd31);
      w_rem_sh   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
      w_rem_ge   = (w_rem_sh >= {1'b0, r_op_a[XLEN-1:0]});
      w_rem_diff = w_rem_sh[XLEN-1:0] - r_op_a[XLEN-1:0];
      if (r_state == S_MUL)
         w_acc_step = r_op_b[0] ? (r_acc + r_op_a) : r_acc;
      else if (w_rem_ge)
         w_acc_step = {w_rem_diff, r_acc[XLEN-2:0], 1'b1};
      else
         w_acc_step = {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
      w_prod = r_neg_q ? -w_acc_step : w_acc_step;
      w_quo  = r_neg_q ? -w_acc_step[XLEN-1:0] : w_acc_step[XLEN-1:0];
      w_rem  = r_neg_r ? -w_acc_step[2*XLEN-1:XLEN] : w_acc_step[2*XLEN-1:XLEN];
      if (r_state == S_MUL)
         w_step_res = (r_funct3[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
      else
         w_step_res = r_funct3[1] ? w_rem : w_quo;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (flush) begin
         w_state_nxt = S_IDLE;
      end else if (w_capture) begin
`ifdef EX_MULDIV_EN
         if (!muldiv)
            w_state_nxt = S_DONE;
         else if (!funct3[2])
            w_state_nxt = S_MUL;
         else if (w_div_fast)
            w_state_nxt = S_DONE;
         else
            w_state_nxt = S_DIV;
`else
         w_state_nxt = S_DONE;
`endif
      end else begin
         case (r_state)
            S_DONE: if (ready_next) w_state_nxt = S_IDLE;
`ifdef EX_MULDIV_EN
            S_MUL, S_DIV: if (w_last) w_state_nxt = S_DONE;
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_result    <= '0;
         r_pc        <= '0;
         r_csrs      <= '0;
         r_rs2_value <= '0;
         r_inst      <= '0;
         r_rd        <= '0;
         r_funct3    <= '0;
         r_csr_wen   <= '0;
         r_mem_ren   <= 1'b0;
         r_mem_wen   <= 1'b0;
         r_R_wen     <= 1'b0;
         r_jump_flag <= 1'b0;
`ifdef EX_MULDIV_EN
         r_acc       <= '0;
         r_op_a      <= '0;
         r_op_b      <= '0;
         r_cnt       <= '0;
         r_neg_q     <= 1'b0;
         r_neg_r     <= 1'b0;
`endif
      end else begin
         if (w_capture) begin
            r_pc        <= pc;
            r_csrs      <= csrs;
            r_rs2_value <= rs2_value;
            r_inst      <= inst;
            r_rd        <= rd;
            r_funct3    <= funct3;
            r_csr_wen   <= csr_wen;
            r_mem_ren   <= mem_ren;
            r_mem_wen   <= mem_wen;
            r_R_wen     <= R_wen;
            r_jump_flag <= jump_flag;
`ifdef EX_MULDIV_EN
            r_cnt   <= '0;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_op_b  <= w_b_mag;
            if (funct3[2]) begin
               r_acc  <= {{XLEN{1'b0}}, w_a_mag};
               r_op_a <= {{XLEN{1'b0}}, w_b_mag};
            end else begin
               r_acc  <= '0;
               r_op_a <= {{XLEN{1'b0}}, w_a_mag};
            end
            if (!muldiv)
               r_result <= w_alu;
            else if (w_div_fast)
               r_result <= w_fast_res;
`else
            r_result <= muldiv ? '0 : w_alu;
`endif
         end
`ifdef EX_MULDIV_EN
         else if (!flush && w_busy) begin
            r_acc <= w_acc_step;
            r_cnt <= r_cnt + 5'd1;
            if (r_state == S_MUL) begin
               r_op_a <= r_op_a << 1;
               r_op_b <= r_op_b >> 1;
            end
            if (w_last)
               r_result <= w_step_res;
         end
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
//==============================================================================
// Module   : tb_ex_stage
// Brief    : Self-checking bench for ex_stage: latency-level reference model
//            plus directed vectors with literal expectations.
// Revision : 1.0
//==============================================================================
module tb_ex_stage;

`ifdef EX_MULDIV_EN
   localparam bit MD_EN = 1'b1;
`else
   localparam bit MD_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] pc = '0, src1 = '0, src2 = '0, csrs = '0, rs2_value = '0, inst = '0;
   logic [3:0]  alu_op = '0;
   logic [2:0]  funct3 = '0;
   logic        muldiv = 1'b0, mem_ren = 1'b0, mem_wen = 1'b0, R_wen = 1'b0, jump_flag = 1'b0;
   logic [3:0]  csr_wen = '0;
   logic [4:0]  rd = '0;
   logic        valid_last = 1'b0, ready_next = 1'b1, flush = 1'b0;
   logic        ready_last, valid_next;
   logic [31:0] Ex_result_next, pc_next, csrs_next, rs2_value_next, inst_next;
   logic [4:0]  rd_next;
   logic [2:0]  funct3_next;
   logic [3:0]  csr_wen_next;
   logic        mem_ren_next, mem_wen_next, R_wen_next, jump_flag_next;

   int tests = 0;
   int fails = 0;

   ex_stage #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .pc(pc), .src1(src1), .src2(src2), .csrs(csrs), .rs2_value(rs2_value), .inst(inst),
      .alu_op(alu_op), .funct3(funct3), .muldiv(muldiv),
      .mem_ren(mem_ren), .mem_wen(mem_wen), .R_wen(R_wen), .jump_flag(jump_flag),
      .csr_wen(csr_wen), .rd(rd),
      .valid_last(valid_last), .ready_last(ready_last), .valid_next(valid_next),
      .ready_next(ready_next), .flush(flush),
      .Ex_result_next(Ex_result_next), .pc_next(pc_next), .csrs_next(csrs_next),
      .rs2_value_next(rs2_value_next), .inst_next(inst_next), .rd_next(rd_next),
      .funct3_next(funct3_next), .csr_wen_next(csr_wen_next),
      .mem_ren_next(mem_ren_next), .mem_wen_next(mem_wen_next),
      .R_wen_next(R_wen_next), .jump_flag_next(jump_flag_next)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Architectural result straight from RV32I/M arithmetic definitions.
   function automatic logic [31:0] golden(input logic [3:0] op, input logic md,
                                          input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
      logic signed [63:0] sa, sb, ua, ub;
      logic [63:0]        p;
      logic signed [31:0] qa, qb;
      logic               ovf;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'h0, a};
      ub = {32'h0, b};
      qa = a;
      qb = b;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      if (md) begin
         if (!MD_EN) return 32'h0;
         case (f3)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
               if (b == 0) return 32'hFFFF_FFFF;
               if (ovf) return 32'h8000_0000;
               return qa / qb;
            end
            3'd5: begin
               if (b == 0) return 32'hFFFF_FFFF;
               return a / b;
            end
            3'd6: begin
               if (b == 0) return a;
               if (ovf) return 32'h0;
               return qa % qb;
            end
            default: begin
               if (b == 0) return a;
               return a % b;
            end
         endcase
      end
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a << b[4:0];
         4'd3:    return (qa < qb) ? 32'd1 : 32'd0;
         4'd4:    return (a < b) ? 32'd1 : 32'd0;
         4'd5:    return a ^ b;
         4'd6:    return a >> b[4:0];
         4'd7:    return qa >>> b[4:0];
         4'd8:    return a | b;
         4'd9:    return a & b;
         4'd10:   return b;
         default: return 32'h0;
      endcase
   endfunction

   function automatic int latency(input logic md, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] b);
      if (!md || !MD_EN) return 1;
      if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
      return 33;
   endfunction

   // Reference model: busy count, pending result and captured sideband.
   logic        m_valid = 1'b0;
   int          m_busy = 0;
   logic        m_cap = 1'b0;
   int          m_lat = 0;
   logic [31:0] m_exp = '0, m_pc = '0, m_inst = '0, m_csrs = '0, m_rs2 = '0;
   logic [15:0] m_side = '0;

   function automatic logic model_ready();
      return (m_busy == 0) && (!m_valid || ready_next);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid = 1'b0;
         m_busy  = 0;
      end else begin
         m_cap = valid_last && model_ready() && !flush;
         if (flush) begin
            m_valid = 1'b0;
            m_busy  = 0;
         end else if (m_cap) begin
            m_exp  = golden(alu_op, muldiv, funct3, src1, src2);
            m_pc   = pc;
            m_inst = inst;
            m_csrs = csrs;
            m_rs2  = rs2_value;
            m_side = {rd, funct3, csr_wen, mem_ren, mem_wen, R_wen, jump_flag};
            m_lat  = latency(muldiv, funct3, src1, src2);
            if (m_lat == 1) begin
               m_valid = 1'b1;
               m_busy  = 0;
            end else begin
               m_valid = 1'b0;
               m_busy  = m_lat - 1;
            end
         end else if (m_busy > 0) begin
            m_busy = m_busy - 1;
            if (m_busy == 0) m_valid = 1'b1;
         end else if (m_valid && ready_next) begin
            m_valid = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("mdl_valid", {31'h0, valid_next}, {31'h0, m_valid});
         check("mdl_ready", {31'h0, ready_last}, {31'h0, model_ready()});
         if (m_valid) begin
            check("mdl_result", Ex_result_next, m_exp);
            check("mdl_pc", pc_next, m_pc);
            check("mdl_inst", inst_next, m_inst);
            check("mdl_csrs", csrs_next, m_csrs);
            check("mdl_rs2", rs2_value_next, m_rs2);
            check("mdl_side", {16'h0, rd_next, funct3_next, csr_wen_next, mem_ren_next,
                               mem_wen_next, R_wen_next, jump_flag_next}, {16'h0, m_side});
         end
      end
   end

   task automatic randomize_side();
      pc        = $urandom;
      inst      = $urandom;
      csrs      = $urandom;
      rs2_value = $urandom;
      rd        = 5'($urandom);
      csr_wen   = 4'($urandom);
      mem_ren   = 1'($urandom);
      mem_wen   = 1'($urandom);
      R_wen     = 1'($urandom);
      jump_flag = 1'($urandom);
   endtask

   // Called #1 after a rising edge; returns #1 after the capturing edge.
   task automatic issue(input logic [3:0] op, input logic md, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b);
      int n;
      alu_op = op; muldiv = md; funct3 = f3; src1 = a; src2 = b;
      randomize_side();
      valid_last = 1'b1;
      n = 0;
      @(negedge clk);
      while (!ready_last && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!ready_last) check("issue_timeout", 32'h0, 32'h1);
      @(posedge clk);
      #1 valid_last = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 1;
      while (!valid_next && lat < 100) begin
         @(posedge clk);
         #1 lat++;
      end
   endtask

   task automatic run_op(input string nm, input logic [3:0] op, input logic md,
                         input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_full, input int lat_full);
      int          lat, el;
      logic [31:0] e;
      e  = (md && !MD_EN) ? 32'h0 : exp_full;
      el = (md && !MD_EN) ? 1 : lat_full;
      issue(op, md, f3, a, b);
      wait_valid(lat);
      check({nm, "_lat"}, 32'(lat), 32'(el));
      check({nm, "_res"}, Ex_result_next, e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int lat;
      #12;
      check("rst_valid", {31'h0, valid_next}, 32'h0);
      check("rst_result", Ex_result_next, 32'h0);
      check("rst_pc", pc_next, 32'h0);
      check("rst_side", {16'h0, rd_next, funct3_next, csr_wen_next, mem_ren_next,
                         mem_wen_next, R_wen_next, jump_flag_next}, 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1 check("rst_ready", {31'h0, ready_last}, 32'h1);

      run_op("add",   4'd0,  1'b0, 3'd0, 32'd5,          32'd7,          32'd12,         1);
      run_op("sub",   4'd1,  1'b0, 3'd0, 32'd5,          32'd7,          32'hFFFF_FFFE,  1);
      run_op("sll",   4'd2,  1'b0, 3'd0, 32'd1,          32'h3F,         32'h8000_0000,  1);
      run_op("slt",   4'd3,  1'b0, 3'd0, 32'hFFFF_FFFF,  32'd1,          32'd1,          1);
      run_op("sltu",  4'd4,  1'b0, 3'd0, 32'hFFFF_FFFF,  32'd1,          32'd0,          1);
      run_op("xor",   4'd5,  1'b0, 3'd0, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'h0FF0_0FF0,  1);
      run_op("srl",   4'd6,  1'b0, 3'd0, 32'h8000_0000,  32'd4,          32'h0800_0000,  1);
      run_op("sra",   4'd7,  1'b0, 3'd0, 32'h8000_0000,  32'd4,          32'hF800_0000,  1);
      run_op("or",    4'd8,  1'b0, 3'd0, 32'h0F0,        32'h00F,        32'h0FF,        1);
      run_op("and",   4'd9,  1'b0, 3'd0, 32'hFF00,       32'h0FF0,       32'h0F00,       1);
      run_op("pass",  4'd10, 1'b0, 3'd0, 32'h1,          32'h1234_5678,  32'h1234_5678,  1);
      run_op("op13",  4'd13, 1'b0, 3'd0, 32'h1,          32'h2,          32'h0,          1);

      run_op("mulh",   4'd0, 1'b1, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
      run_op("mulhu",  4'd0, 1'b1, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
      run_op("mul",    4'd0, 1'b1, 3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
      run_op("mulhsu", 4'd0, 1'b1, 3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33);
      run_op("div",    4'd0, 1'b1, 3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
      run_op("rem",    4'd0, 1'b1, 3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
      run_op("divu",   4'd0, 1'b1, 3'd5, 32'd100,       32'd7,         32'd14,        33);
      run_op("remu",   4'd0, 1'b1, 3'd7, 32'd100,       32'd7,         32'd2,         33);
      run_op("divu0",  4'd0, 1'b1, 3'd5, 32'd10,        32'd0,         32'hFFFF_FFFF, 1);
      run_op("remu0",  4'd0, 1'b1, 3'd7, 32'd10,        32'd0,         32'd10,        1);
      run_op("divovf", 4'd0, 1'b1, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      run_op("removf", 4'd0, 1'b1, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1);

      // Downstream stall: result held, upstream offer refused until release.
      ready_next = 1'b0;
      issue(4'd0, 1'b0, 3'd0, 32'd100, 32'd23);
      wait_valid(lat);
      check("bp_lat", 32'(lat), 32'd1);
      alu_op = 4'd1; muldiv = 1'b0; src1 = 32'd50; src2 = 32'd8;
      randomize_side();
      valid_last = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_valid", {31'h0, valid_next}, 32'h1);
         check("bp_res", Ex_result_next, 32'd123);
         check("bp_ready", {31'h0, ready_last}, 32'h0);
      end
      #1 ready_next = 1'b1;
      @(posedge clk);
      #1 valid_last = 1'b0;
      check("bp_next_valid", {31'h0, valid_next}, 32'h1);
      check("bp_next_res", Ex_result_next, 32'd42);
      @(posedge clk);
      #1;

      // Flush while the divider is at iteration 10.
      issue(4'd0, 1'b1, 3'd5, 32'd1000, 32'd3);
      repeat (10) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      check("fl_valid", {31'h0, valid_next}, 32'h0);
      check("fl_ready", {31'h0, ready_last}, 32'h1);
      repeat (3) @(posedge clk);
      #1 check("fl_still_idle", {31'h0, valid_next}, 32'h0);
      run_op("fl_add", 4'd0, 1'b0, 3'd0, 32'd5, 32'd7, 32'd12, 1);

      // Reset in the middle of a multiply.
      issue(4'd0, 1'b1, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      #2;
      check("mr_valid", {31'h0, valid_next}, 32'h0);
      check("mr_result", Ex_result_next, 32'h0);
      check("mr_pc", pc_next, 32'h0);
      check("mr_inst", inst_next, 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1 check("mr_ready", {31'h0, ready_last}, 32'h1);
      run_op("mr_mulhu", 4'd0, 1'b1, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
      run_op("mr_add",   4'd0, 1'b0, 3'd0, 32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 1);

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
